scpad_dram_req_gen: RTL and testbench

SCPAD_DRAM_REQ_GEN -- requirements
Module: scpad_dram_req_gen

---
 rtl/scpad_dram_req_gen_if.sv | 55 +++++
 rtl/scpad_dram_req_gen.sv | 108 ++++++++++
 tb/tb_scpad_dram_req_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/scpad_dram_req_gen_if.sv
// Handshake and data bundle for the scratchpad-to-DRAM request generator:
// backend transaction request, scratchpad read port and the DRAM sub-request queue.
interface scpad_dram_req_gen_if #(
   parameter int DRAM_ADDR_W = 32,
   parameter int SRAM_ADDR_W = 16
);
   // backend transaction
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_write;
   logic [7:0]             req_id;
   logic [DRAM_ADDR_W-1:0] req_dram_addr;
   logic [SRAM_ADDR_W-1:0] req_sram_addr;
   logic [7:0]             req_total_bytes;
   // scratchpad read port
   logic                   sram_ren;
   logic [SRAM_ADDR_W-1:0] sram_raddr;
   logic                   sram_rvalid;
   logic [127:0]           sram_rdata;
   // DRAM request queue
   logic                   q_valid;
   logic                   q_write;
   logic [7:0]             q_id;
   logic [2:0]             q_sub_id;
   logic [3:0]             q_num_request;
   logic [4:0]             q_num_bytes;
   logic [DRAM_ADDR_W-1:0] q_dram_addr;
   logic [127:0]           q_wdata;
   logic                   queue_full;
   // status pulses
   logic                   done;
   logic                   err;

   // generator side
   modport slave (
      input  req_valid, req_write, req_id, req_dram_addr, req_sram_addr, req_total_bytes,
      output req_ready,
      output sram_ren, sram_raddr,
      input  sram_rvalid, sram_rdata,
      output q_valid, q_write, q_id, q_sub_id, q_num_request, q_num_bytes, q_dram_addr, q_wdata,
      input  queue_full,
      output done, err
   );

   // backend / memory / queue side
   modport master (
      output req_valid, req_write, req_id, req_dram_addr, req_sram_addr, req_total_bytes,
      input  req_ready,
      input  sram_ren, sram_raddr,
      output sram_rvalid, sram_rdata,
      input  q_valid, q_write, q_id, q_sub_id, q_num_request, q_num_bytes, q_dram_addr, q_wdata,
      output queue_full,
      input  done, err
   );
endinterface

// File: rtl/scpad_dram_req_gen.sv
// Splits one backend transaction into 16-byte DRAM sub-requests. Writes fetch
// each beat from the scratchpad before issuing it; reads issue back to back.
module scpad_dram_req_gen #(
   parameter int DRAM_ADDR_W = 32,
   parameter int SRAM_ADDR_W = 16,
   parameter int CHUNK_BYTES = 16,
   parameter int MAX_SUBREQ  = 8
) (
   input  logic                 CLK,
   input  logic                 nRST,
   scpad_dram_req_gen_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SRAM_RD, WAIT_SRAM, ISSUE} state_t;

   localparam logic [8:0]             MAX_BYTES = 9'(MAX_SUBREQ * CHUNK_BYTES);
   localparam logic [DRAM_ADDR_W-1:0] DRAM_STEP = DRAM_ADDR_W'(CHUNK_BYTES);

   state_t                 state, state_nxt;
   logic                   wr_q;
   logic [7:0]             id_q;
   logic [7:0]             total_q;
   logic [DRAM_ADDR_W-1:0] dram_q;
   logic [SRAM_ADDR_W-1:0] sram_q;
   logic [3:0]             nreq_q;
   logic [2:0]             sub_q;
   logic [127:0]           wdata_q;
   logic                   done_q, err_q;

   logic                   accept, req_bad, beat_ok, last_beat;
   logic [3:0]             nreq_calc;
   logic [4:0]             last_bytes;

   assign accept     = bus.req_valid && (state == IDLE);
   assign req_bad    = (bus.req_total_bytes == 8'd0) || ({1'b0, bus.req_total_bytes} > MAX_BYTES);
   assign nreq_calc  = 4'(({1'b0, bus.req_total_bytes} + 9'd15) >> 4);
   assign beat_ok    = (state == ISSUE) && !bus.queue_full;
   assign last_beat  = ({1'b0, sub_q} == (nreq_q - 4'd1));
   // bytes left for the final beat always lands in 1..16
   assign last_bytes = 5'(total_q - {1'b0, sub_q, 4'b0000});

   // state register
   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state: writes loop through the scratchpad read per beat, reads stay in ISSUE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept && !req_bad) state_nxt = bus.req_write ? SRAM_RD : ISSUE;
         SRAM_RD:   state_nxt = WAIT_SRAM;
         WAIT_SRAM: if (bus.sram_rvalid) state_nxt = ISSUE;
         ISSUE:     if (beat_ok) state_nxt = last_beat ? IDLE : (wr_q ? SRAM_RD : ISSUE);
         default:   state_nxt = IDLE;
      endcase
   end

   // transaction context, per-beat address walk and status pulses
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wr_q    <= 1'b0;
         id_q    <= '0;
         total_q <= '0;
         dram_q  <= '0;
         sram_q  <= '0;
         nreq_q  <= '0;
         sub_q   <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= beat_ok && last_beat;
         err_q  <= accept && req_bad;
         if (accept) begin
            wr_q    <= bus.req_write;
            id_q    <= bus.req_id;
            total_q <= bus.req_total_bytes;
            dram_q  <= bus.req_dram_addr;
            sram_q  <= bus.req_sram_addr;
            nreq_q  <= nreq_calc;
            sub_q   <= '0;
            wdata_q <= '0;
         end
         if ((state == WAIT_SRAM) && bus.sram_rvalid) wdata_q <= bus.sram_rdata;
         if (beat_ok) begin
            sub_q  <= sub_q + 3'd1;
            dram_q <= dram_q + DRAM_STEP;
            sram_q <= sram_q + 1'b1;
         end
      end
   end

   // outputs are zeroed outside their active state so idle/reset shows all-zero fields
   assign bus.req_ready     = (state == IDLE);
   assign bus.sram_ren      = (state == SRAM_RD);
   assign bus.sram_raddr    = bus.sram_ren ? sram_q : '0;
   assign bus.q_valid       = (state == ISSUE);
   assign bus.q_write       = bus.q_valid && wr_q;
   assign bus.q_id          = bus.q_valid ? id_q : '0;
   assign bus.q_sub_id      = bus.q_valid ? sub_q : '0;
   assign bus.q_num_request = bus.q_valid ? nreq_q : '0;
   assign bus.q_num_bytes   = !bus.q_valid ? 5'd0 : (last_beat ? last_bytes : 5'd16);
   assign bus.q_dram_addr   = bus.q_valid ? dram_q : '0;
   assign bus.q_wdata       = (bus.q_valid && wr_q) ? wdata_q : '0;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
endmodule

// File: tb/tb_scpad_dram_req_gen.sv
// Scoreboard bench: directed transactions push hand-computed beats and SRAM
// read addresses into queues; a negedge monitor pops and compares.
module tb_scpad_dram_req_gen;
   typedef logic [199:0] w_t;
   typedef struct packed {
      logic         wr;
      logic [7:0]   id;
      logic [2:0]   sub;
      logic [3:0]   nreq;
      logic [4:0]   nb;
      logic [31:0]  addr;
      logic [127:0] wd;
   } beat_t;

   logic CLK = 1'b0;
   logic nRST = 1'b0;

   scpad_dram_req_gen_if bus ();
   scpad_dram_req_gen dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   always #5 CLK = ~CLK;

   beat_t       exp_q[$];
   logic [15:0] ren_q[$];
   int tests = 0, fails = 0;
   int cyc = 0, exp_done_cyc = -1, done_cnt = 0, full_cycles = 0;
   int junk_req = 0, junk_done = 0;
   beat_t cur, e, snap;
   logic  stalled = 1'b0;

   function automatic logic [127:0] pat(input logic [15:0] a);
      return {a, 16'hBEEF, a, 16'hCAFE, a, 16'h1234, a, 16'h5678};
   endfunction

   task automatic chk(input string name, input w_t act, input w_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   task automatic exp_beat(input logic wr, input logic [7:0] id, input logic [2:0] sub,
                           input logic [3:0] nreq, input logic [4:0] nb,
                           input logic [31:0] addr, input logic [127:0] wd);
      exp_q.push_back('{wr, id, sub, nreq, nb, addr, wd});
   endtask

   task automatic send(input logic wr, input logic [7:0] id, input logic [31:0] daddr,
                       input logic [15:0] saddr, input logic [7:0] total);
      int n = 0;
      while (!bus.req_ready && n < 300) begin @(negedge CLK); n++; end
      if (!bus.req_ready) fail_now("send_ready_timeout");
      bus.req_valid       = 1'b1;
      bus.req_write       = wr;
      bus.req_id          = id;
      bus.req_dram_addr   = daddr;
      bus.req_sram_addr   = saddr;
      bus.req_total_bytes = total;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge CLK);
      while (!bus.req_ready && n < 300) begin @(negedge CLK); n++; end
      if (!bus.req_ready) fail_now("idle_timeout");
   endtask

   // scratchpad model: data returns two cycles after each read strobe
   initial begin
      int cnt = 0;
      logic [15:0] a = '0;
      bus.sram_rvalid = 1'b0;
      bus.sram_rdata  = '0;
      forever begin
         @(posedge CLK); #1;
         bus.sram_rvalid = 1'b0;
         bus.sram_rdata  = '0;
         if (junk_req != junk_done) begin
            junk_done++;
            bus.sram_rvalid = 1'b1;
            bus.sram_rdata  = {4{32'hDEADDEAD}};
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.sram_rvalid = 1'b1;
               bus.sram_rdata  = pat(a);
            end
         end
         if (bus.sram_ren) begin
            cnt = 2;
            a   = bus.sram_raddr;
         end
      end
   end

   // monitor: accepted beats, stall stability, done timing, scratchpad read addresses
   always @(negedge CLK) begin
      cyc++;
      cur = '{bus.q_write, bus.q_id, bus.q_sub_id, bus.q_num_request, bus.q_num_bytes,
              bus.q_dram_addr, bus.q_wdata};
      if (bus.q_valid && !bus.queue_full) begin
         if (exp_q.size() == 0) fail_now("unexpected_beat");
         else begin
            e = exp_q.pop_front();
            chk("beat", w_t'(cur), w_t'(e));
            if (e.sub == 3'(e.nreq - 4'd1)) exp_done_cyc = cyc + 1;
         end
      end
      if (bus.q_valid && bus.queue_full) begin
         if (stalled) chk("stall_hold", w_t'(cur), w_t'(snap));
         snap = cur;
         stalled = 1'b1;
         full_cycles++;
      end else stalled = 1'b0;
      if (bus.done) begin
         done_cnt++;
         chk("done_timing", w_t'(cyc), w_t'(exp_done_cyc));
      end
      if (bus.sram_ren) begin
         if (ren_q.size() == 0) fail_now("unexpected_ren");
         else chk("ren_addr", w_t'(bus.sram_raddr), w_t'(ren_q.pop_front()));
      end
   end

   initial begin
      int f0;
      logic [7:0] bad [2];
      bad[0] = 8'd0;
      bad[1] = 8'd129;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_id = '0;
      bus.req_dram_addr = '0; bus.req_sram_addr = '0; bus.req_total_bytes = '0;
      bus.queue_full = 1'b0;

      // reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", w_t'(bus.req_ready), w_t'(1));
      chk("rst_q_valid", w_t'(bus.q_valid), w_t'(0));
      chk("rst_ren", w_t'(bus.sram_ren), w_t'(0));
      chk("rst_done", w_t'(bus.done), w_t'(0));
      chk("rst_err", w_t'(bus.err), w_t'(0));
      chk("rst_nbytes", w_t'(bus.q_num_bytes), w_t'(0));
      chk("rst_addr", w_t'(bus.q_dram_addr), w_t'(0));
      @(posedge CLK); #1 nRST = 1'b1;

      // read 40 bytes from 0x1000
      exp_beat(0, 8'h11, 3'd0, 4'd3, 5'd16, 32'h1000, '0);
      exp_beat(0, 8'h11, 3'd1, 4'd3, 5'd16, 32'h1010, '0);
      exp_beat(0, 8'h11, 3'd2, 4'd3, 5'd8,  32'h1020, '0);
      send(0, 8'h11, 32'h1000, 16'd0, 8'd40);
      wait_idle();

      // stray rvalid while idle, then write 32 bytes from scratchpad beat 5
      junk_req++;
      repeat (2) @(posedge CLK); #1;
      ren_q.push_back(16'd5);
      ren_q.push_back(16'd6);
      exp_beat(1, 8'h22, 3'd0, 4'd2, 5'd16, 32'h2000, pat(16'd5));
      exp_beat(1, 8'h22, 3'd1, 4'd2, 5'd16, 32'h2010, pat(16'd6));
      send(1, 8'h22, 32'h2000, 16'd5, 8'd32);
      wait_idle();

      // single-beat read with the queue full for 4 cycles
      bus.queue_full = 1'b1;
      f0 = full_cycles;
      exp_beat(0, 8'h33, 3'd0, 4'd1, 5'd16, 32'h3000, '0);
      send(0, 8'h33, 32'h3000, 16'd0, 8'd16);
      repeat (4) @(posedge CLK); #1;
      bus.queue_full = 1'b0;
      wait_idle();
      chk("stall_cycles", w_t'(full_cycles - f0), w_t'(4));

      // illegal lengths
      for (int i = 0; i < 2; i++) begin
         send(0, 8'h44, 32'h4000, 16'd0, bad[i]);
         @(negedge CLK);
         chk("err_pulse", w_t'(bus.err), w_t'(1));
         chk("err_ready", w_t'(bus.req_ready), w_t'(1));
         @(negedge CLK);
         chk("err_clear", w_t'(bus.err), w_t'(0));
         chk("err_no_valid", w_t'(bus.q_valid), w_t'(0));
      end

      // DRAM address wrap
      exp_beat(0, 8'h55, 3'd0, 4'd2, 5'd16, 32'hFFFF_FFF0, '0);
      exp_beat(0, 8'h55, 3'd1, 4'd2, 5'd16, 32'h0000_0000, '0);
      send(0, 8'h55, 32'hFFFF_FFF0, 16'd0, 8'd32);
      wait_idle();

      // reset while waiting on the scratchpad in a 3-beat write
      ren_q.push_back(16'h20);
      send(1, 8'h66, 32'h5000, 16'h20, 8'd48);
      @(posedge CLK); #1 nRST = 1'b0;
      @(posedge CLK); #1 nRST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_ready", w_t'(bus.req_ready), w_t'(1));
      chk("mid_rst_q_valid", w_t'(bus.q_valid), w_t'(0));
      chk("mid_rst_ren", w_t'(bus.sram_ren), w_t'(0));
      chk("mid_rst_done", w_t'(bus.done), w_t'(0));

      // 1-byte read, then a 128-byte read accepted in its done cycle
      exp_beat(0, 8'h77, 3'd0, 4'd1, 5'd1, 32'h40, '0);
      send(0, 8'h77, 32'h40, 16'd0, 8'd1);
      wait_idle();
      for (int i = 0; i < 8; i++)
         exp_beat(0, 8'h88, 3'(i), 4'd8, 5'd16, 32'h100 + 32'(16 * i), '0);
      send(0, 8'h88, 32'h100, 16'd0, 8'd128);
      wait_idle();

      repeat (4) @(negedge CLK);
      chk("done_count", w_t'(done_cnt), w_t'(6));
      chk("beats_left", w_t'(exp_q.size()), w_t'(0));
      chk("rens_left", w_t'(ren_q.size()), w_t'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
